// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the multicycle MIPS unified memory between the CPU and a DMA/loader port.
// Define ARB_ROUND_ROBIN_EN to alternate grants on contention; otherwise the CPU has fixed priority.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_re,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              owner
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  count;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              lat_we;
  logic              cpu_req;
  logic              grant_dma;
  logic              grant_we;

  assign cpu_req = cpu_rd | cpu_wr;

`ifdef ARB_ROUND_ROBIN_EN
  // On contention the requester that did not win the previous grant goes first.
  assign grant_dma = dma_req & (~cpu_req | ~owner);
`else
  assign grant_dma = dma_req & ~cpu_req;
`endif

  // A CPU cycle with both MemRead and MemWrite set is treated as a write.
  assign grant_we = grant_dma ? dma_we : cpu_wr;

  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      count     <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_we    <= 1'b0;
      owner     <= 1'b0;
      mem_re    <= 1'b0;
      mem_we    <= 1'b0;
      cpu_ready <= 1'b0;
      dma_ack   <= 1'b0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req | dma_req) begin
            owner     <= grant_dma;
            lat_addr  <= grant_dma ? dma_addr : cpu_addr;
            lat_wdata <= grant_dma ? dma_wdata : cpu_wdata;
            lat_we    <= grant_we;
            mem_re    <= ~grant_we;
            mem_we    <= grant_we;
            count     <= CNT_W'(MEM_LAT - 1);
            state     <= BUSY;
          end
        end
        BUSY: begin
          // Memory data is only valid on the final cycle of the access.
          if (count == '0) begin
            if (!lat_we) begin
              if (owner) dma_rdata <= mem_rdata;
              else       cpu_rdata <= mem_rdata;
            end
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            cpu_ready <= ~owner;
            dma_ack   <= owner;
            state     <= RESP;
          end else begin
            count <= count - 1'b1;
          end
        end
        RESP: begin
          cpu_ready <= 1'b0;
          dma_ack   <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
